// File: rtl/tone_audio_pkg.sv
// Shared widths, envelope states and sample formation for the tone I2S output stage.
// Pure declarations; no latency or backpressure.
package tone_audio_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int AMP_W      = 15;
    localparam int FRAME_BITS = 64;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } env_state_t;

    // Magnitude is zero-extended before negation so 0x7800 becomes 0x8800, never wraps.
    function automatic logic [SAMPLE_W-1:0] signed_sample(input logic positive,
                                                         input logic [AMP_W-1:0] amp);
        logic [SAMPLE_W-1:0] mag;
        mag = {1'b0, amp};
        return positive ? mag : (~mag + SAMPLE_W'(1));
    endfunction

endpackage

// File: rtl/i2s_clk_div.sv
// I2S bit clock / bit index generator; frame_tick is combinational on the clk edge where bit_idx wraps.
// Free-running, no backpressure.
module i2s_clk_div
    import tone_audio_pkg::*;
#(
    parameter int BCLK_HALF = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic             aud_bclk,
    output logic [BIT_W-1:0] bit_idx,
    output logic             frame_tick
);

    localparam int CNT_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BCLK_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    logic [CNT_W-1:0] bclk_cnt;
    logic             half_end;

    assign half_end   = (bclk_cnt == CNT_LAST);
    // Bit index only advances on the falling toggle, so a wrap implies aud_bclk is high now.
    assign frame_tick = half_end && aud_bclk && (bit_idx == BIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_cnt <= '0;
            aud_bclk <= 1'b0;
            bit_idx  <= '0;
        end else if (half_end) begin
            bclk_cnt <= '0;
            aud_bclk <= ~aud_bclk;
            if (aud_bclk) begin
                bit_idx <= bit_idx + BIT_W'(1);
            end
        end else begin
            bclk_cnt <= bclk_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tone_i2s_tx.sv
// Speaker square wave -> enveloped 16-bit sample -> I2S; new sample each 64-BCLK frame, heard next frame.
// Free-running, no backpressure; ramping envelope only with TONE_I2S_ENVELOPE_EN defined.
module tone_i2s_tx
    import tone_audio_pkg::*;
#(
    parameter int BCLK_HALF = 16,
    parameter int ENV_STEP  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       speaker_in,
    input  logic       enable,
    input  logic [3:0] volume,
    output logic       aud_bclk,
    output logic       aud_daclrck,
    output logic       aud_dacdat,
    output logic       sample_strobe,
    output logic       env_busy
);

    logic [BIT_W-1:0]    bit_idx;
    logic                frame_tick;
    logic [AMP_W-1:0]    amp;
    logic [AMP_W-1:0]    amp_nxt;
    logic [AMP_W-1:0]    target;
    logic [SAMPLE_W-1:0] sample;
    env_state_t          state;
    env_state_t          state_nxt;

    i2s_clk_div #(
        .BCLK_HALF (BCLK_HALF)
    ) u_clk_div (
        .clk        (clk),
        .reset      (reset),
        .aud_bclk   (aud_bclk),
        .bit_idx    (bit_idx),
        .frame_tick (frame_tick)
    );

    assign target = enable ? {volume, 11'b0} : '0;

`ifdef TONE_I2S_ENVELOPE_EN
    localparam logic [SAMPLE_W-1:0] STEP_W = SAMPLE_W'(ENV_STEP);

    logic [SAMPLE_W-1:0] up_sum;
    logic [SAMPLE_W-1:0] dn_lim;
    logic [AMP_W-1:0]    amp_up;
    logic [AMP_W-1:0]    amp_dn;

    always_comb begin
        up_sum = {1'b0, amp} + STEP_W;
        dn_lim = {1'b0, target} + STEP_W;
        amp_up = (up_sum > {1'b0, target}) ? target : up_sum[AMP_W-1:0];
        amp_dn = ({1'b0, amp} <= dn_lim) ? target : (amp - STEP_W[AMP_W-1:0]);
    end

    always_comb begin
        state_nxt = state;
        amp_nxt   = amp;
        case (state)
            IDLE: begin
                if (target != '0) state_nxt = ATTACK;
            end
            SUSTAIN: begin
                if (target > amp)      state_nxt = ATTACK;
                else if (target < amp) state_nxt = RELEASE;
            end
            ATTACK, RELEASE: begin
                // Direction follows the live target, so a crossing target flips ATTACK/RELEASE directly.
                if (target > amp)      amp_nxt = amp_up;
                else if (target < amp) amp_nxt = amp_dn;
                if (amp_nxt == target)     state_nxt = (target == '0) ? IDLE : SUSTAIN;
                else if (target > amp_nxt) state_nxt = ATTACK;
                else                       state_nxt = RELEASE;
            end
            default: begin
                state_nxt = IDLE;
                amp_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            env_busy <= 1'b0;
        end else if (frame_tick) begin
            env_busy <= (state_nxt == ATTACK) || (state_nxt == RELEASE);
        end
    end
`else
    always_comb begin
        amp_nxt   = target;
        state_nxt = (target == '0) ? IDLE : SUSTAIN;
    end

    assign env_busy = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            amp           <= '0;
            sample        <= '0;
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= frame_tick;
            if (frame_tick) begin
                state  <= state_nxt;
                amp    <= amp_nxt;
                sample <= signed_sample(speaker_in, amp);
            end
        end
    end

    logic [4:0]          slot;
    logic [SAMPLE_W-1:0] shifted;

    // Slot 0 of each half-frame is the I2S delay bit; slots 1..16 carry the word MSB first.
    always_comb begin
        slot        = bit_idx[4:0];
        shifted     = sample << (slot - 5'd1);
        aud_dacdat  = (slot != 5'd0) && (slot <= 5'd16) && shifted[SAMPLE_W-1];
        aud_daclrck = bit_idx[BIT_W-1];
    end

endmodule

// File: tb/tb_tone_i2s_tx.sv
module tb_tone_i2s_tx;

    localparam int BH        = 2;
    localparam int STEP      = 'h300;
    localparam int FRAME_CLK = 64 * 2 * BH;
`ifdef TONE_I2S_ENVELOPE_EN
    localparam bit ENV = 1'b1;
`else
    localparam bit ENV = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       speaker_in = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] volume = 4'd0;
    logic       aud_bclk, aud_daclrck, aud_dacdat, sample_strobe, env_busy;

    tone_i2s_tx #(
        .BCLK_HALF (BH),
        .ENV_STEP  (STEP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .speaker_in    (speaker_in),
        .enable        (enable),
        .volume        (volume),
        .aud_bclk      (aud_bclk),
        .aud_daclrck   (aud_daclrck),
        .aud_dacdat    (aud_dacdat),
        .sample_strobe (sample_strobe),
        .env_busy      (env_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: amplitude, ramp flag, sample being transmitted, expected busy flag.
    int          m_amp = 0;
    bit          m_ramp = 1'b0;
    logic [15:0] exp_sample = 16'h0;
    bit          exp_busy = 1'b0;

    task automatic model_latch();
        int tgt;
        tgt = enable ? int'(volume) * 2048 : 0;
        exp_sample = speaker_in ? 16'(m_amp) : 16'(-m_amp);
        if (ENV) begin
            if (m_ramp) begin
                if (m_amp < tgt)      m_amp = (m_amp + STEP > tgt) ? tgt : m_amp + STEP;
                else if (m_amp > tgt) m_amp = (m_amp - STEP < tgt) ? tgt : m_amp - STEP;
            end
            m_ramp = (m_amp != tgt);
        end else begin
            m_amp  = tgt;
            m_ramp = 1'b0;
        end
        exp_busy = m_ramp;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        check("reset_outputs", {aud_bclk, aud_daclrck, aud_dacdat, sample_strobe, env_busy}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_amp = 0; m_ramp = 1'b0; exp_sample = 16'h0; exp_busy = 1'b0;
    endtask

    // One frame starting just after a latch (or reset release); checks every clk and the closing latch.
    task automatic run_frame(input bit rnd, input int abort_at,
                             output logic [15:0] w_l, output logic [15:0] w_r, output bit busy);
        int  bclk_err = 0, lrck_err = 0, dat_err = 0, stb_err = 0;
        int  chg_at;
        int  bitn, slot;
        bit  prev_bclk = 1'b0;
        bit  aborted = 1'b0;
        bit  e_bclk, e_lrck, e_dat;
        w_l = 16'h0; w_r = 16'h0; busy = 1'b0;
        chg_at = rnd ? int'($urandom_range(1, FRAME_CLK - 1)) : 0;
        for (int m = 1; m <= FRAME_CLK; m++) begin
            @(negedge clk);
            bitn   = (m / (2 * BH)) % 64;
            slot   = bitn % 32;
            e_bclk = ((m / BH) % 2) == 1;
            e_lrck = bitn >= 32;
            e_dat  = (slot >= 1 && slot <= 16) ? exp_sample[16 - slot] : 1'b0;
            if (aud_bclk !== e_bclk) bclk_err++;
            if (aud_daclrck !== e_lrck) lrck_err++;
            if (aud_dacdat !== e_dat) dat_err++;
            if (sample_strobe !== (m == FRAME_CLK)) stb_err++;
            if (!prev_bclk && aud_bclk === 1'b1 && slot >= 1 && slot <= 16) begin
                if (bitn < 32) w_l[16 - slot] = aud_dacdat;
                else           w_r[16 - slot] = aud_dacdat;
            end
            prev_bclk = (aud_bclk === 1'b1);
            if (m == abort_at) begin
                aborted = 1'b1;
                break;
            end
            if (rnd && m == chg_at) begin
                enable     = 1'($urandom_range(0, 1));
                volume     = 4'($urandom_range(0, 15));
                speaker_in = 1'($urandom_range(0, 1));
            end
        end
        check("bclk_wave", bclk_err, 0);
        check("lrck_wave", lrck_err, 0);
        check("dacdat_wave", dat_err, 0);
        if (!aborted) begin
            check("strobe_timing", stb_err, 0);
            check("word_left", w_l, exp_sample);
            check("word_right", w_r, exp_sample);
            model_latch();
            busy = (env_busy === 1'b1);
            check("env_busy", env_busy, exp_busy);
        end
    endtask

    logic [15:0] wl, wr;
    bit          b;
    int          busy_cnt;

    initial begin
        enable = 1'b1; volume = 4'd15; speaker_in = 1'b1;
        do_reset();

        busy_cnt = 0;
        repeat (45) begin
            run_frame(1'b0, 0, wl, wr, b);
            busy_cnt += int'(b);
        end
        check("attack_busy_frames", busy_cnt, ENV ? 40 : 0);
        check("full_scale_word", wl, 16'h7800);

        enable = 1'b0;
        busy_cnt = 0;
        repeat (45) begin
            run_frame(1'b0, 0, wl, wr, b);
            busy_cnt += int'(b);
        end
        check("release_busy_frames", busy_cnt, ENV ? 40 : 0);
        repeat (4) begin
            speaker_in = 1'($urandom_range(0, 1));
            run_frame(1'b0, 0, wl, wr, b);
            check("silent_word", wl, 16'h0);
        end

        enable = 1'b1; volume = 4'd4; speaker_in = 1'b0;
        repeat (25) run_frame(1'b0, 0, wl, wr, b);
        check("vol4_left", wl, 16'hE000);
        check("vol4_right", wr, 16'hE000);

        repeat (30) run_frame(1'b1, 0, wl, wr, b);

        run_frame(1'b0, 20 * 2 * BH + 1, wl, wr, b);
        enable = 1'b0; volume = 4'd8; speaker_in = 1'b1;
        do_reset();
        enable = 1'b1;
        repeat (3) run_frame(1'b0, 0, wl, wr, b);
        check("vol8_after_reset", wl, ENV ? 16'h0 : 16'h4000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tone_i2s_tx.md
# tone_i2s_tx

Audio output stage sitting directly downstream of the square-wave tone generator. Takes its 1-bit `speaker` signal, scales it to a signed 16-bit sample under a volume setting with an attack/release envelope, and serializes it as I2S (BCLK, DACLRCK, DACDAT) to the board audio codec. Both channels carry the same sample. Codec register setup over I2C is out of scope.

## Interface
- `BCLK_HALF`, 16: clk cycles per BCLK half-period. BCLK = clk/32; one frame = 64 BCLK = 2048 clk, giving 24.414 kHz at 50 MHz.
- `ENV_STEP`, 8: amplitude change per frame while ramping (15-bit units).
- `clk  in  1`: system clock.
- `reset  in  1`: synchronous, active-high.
- `speaker_in  in  1`: tone generator square wave.
- `enable  in  1`: note gate. High selects the volume target; low releases toward 0.
- `volume  in  4`: target amplitude = {volume, 11'b0}. Maximum 15'h7800.
- `aud_bclk  out  1`: I2S bit clock.
- `aud_daclrck  out  1`: word select. 0 = left, 1 = right.
- `aud_dacdat  out  1`: serial data, MSB first.
- `sample_strobe  out  1`: one-clk pulse when a new sample is latched.
- `env_busy  out  1`: high in ATTACK or RELEASE.

## Operation
- Divider `bclk_cnt` counts 0..BCLK_HALF-1. At the terminal count it wraps to 0 and `aud_bclk` toggles.
- On each BCLK falling toggle (1→0), `bit_idx` (6 bits) increments and wraps 63→0.
- Outputs update on that same clk:
  - `aud_daclrck` = bit_idx[5].
  - `aud_dacdat` = sample[16 − (bit_idx mod 32)] for (bit_idx mod 32) in 1..16, else 0. The MSB appears one BCLK after the LRCK edge (standard I2S).
- Frame latch happens on the 63→0 transition:
  - `sample_strobe` pulses.
  - sample ← speaker_in ? {1'b0, amp} : −{1'b0, amp}, two's complement, 16 bits, using `amp` before this frame's update.
  - amp = 0 gives sample 0 regardless of speaker_in.
- Envelope FSM. States update only at the frame latch; target = enable ? {volume, 11'b0} : 0.
  - IDLE: amp = 0, target = 0. Goes to ATTACK if target > 0.
  - ATTACK: amp ← min(amp + ENV_STEP, target). Goes to SUSTAIN when the result equals target.
  - SUSTAIN: amp held. Goes to ATTACK if target > amp; goes to RELEASE if target < amp.
  - RELEASE: amp ← max(amp − ENV_STEP, target). Goes to IDLE if the result is 0 and target is 0. Goes to SUSTAIN if the result equals target and target is nonzero.
  - A direction change mid-ramp (target crosses amp) switches directly between ATTACK and RELEASE.
- Arithmetic:
  - amp is 15 bits unsigned; ramp sums use 16 bits and are then clamped to target, so there is no wrap.
  - Negation is done in 16 bits. Maximum magnitude 0x7800 gives 0x8800 when negative.

## Timing
- Reset values: `aud_bclk` 0, `aud_daclrck` 0, `aud_dacdat` 0, `sample_strobe` 0, `env_busy` 0. bclk_cnt, bit_idx and amp are 0; state is IDLE; sample is 0.
- Reset mid-frame aborts the current word. The first frame after reset outputs zeros; the first latch comes 2048 clk after reset deasserts.
- Latency: a speaker_in change is heard in the next latched frame, at most 2048 + 32 clk after the change.
- `enable` and `volume` are sampled only at the latch. Changes between latches are never seen mid-frame.
- `env_busy` is registered and changes on the latch clk.

## Configuration
- `TONE_I2S_ENVELOPE_EN` defined: ramping FSM as described.
- Not defined: at each latch amp ← target directly; state is only IDLE or SUSTAIN; `env_busy` is tied to 0.

## Structure
- Package `tone_audio_pkg` holds:
  - SAMPLE_W = 16, AMP_W = 15, FRAME_BITS = 64.
  - Envelope state enum (IDLE, ATTACK, SUSTAIN, RELEASE).
- Sub-module `i2s_clk_div` contains bclk_cnt, `aud_bclk`, bit_idx, and a one-clk `frame_tick` on wrap.
- The top level contains the envelope FSM, sample formation and the data mux.

## Test plan
- Reset released, enable=1, volume=15, speaker_in=1, envelope on:
  - amp reaches 0x7800 after 3840 frames.
  - `env_busy` falls on the same latch.
  - The left word is 0x7800 MSB-first on bits 1..16.
- SUSTAIN at volume=15, enable dropped to 0:
  - amp decreases by 8 per frame and reaches 0 after 3840 frames.
  - State returns to IDLE and DACDAT stays 0.
- volume=4, amp=0x2000, speaker_in=0: both words are 0xE000.
- BCLK and LRCK waveform check:
  - BCLK period is 32 clk.
  - LRCK toggles every 1024 clk.
  - The DACDAT MSB is valid on the second BCLK rising edge after the LRCK edge.
- Reset asserted at bit_idx=20, held 3 clk: all outputs go to 0 on the next clk and the first `sample_strobe` arrives 2048 clk after release.
- Macro undefined, enable 0→1 at volume=8: amp = 0x4000 at the first latch and `env_busy` stays 0.
